stage_execute: RTL and testbench



---
 rtl/core_pkg.sv | 23 ++
 rtl/stage_execute_if.sv | 45 ++++
 rtl/lane_mul_seq.sv | 63 ++++++
 rtl/stage_execute.sv | 114 +++++++++++
 tb/tb_stage_execute.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types: lane geometry, ALU opcodes and multiply sequencer states.
package core_pkg;
  localparam int XLEN  = 32;
  localparam int LANES = 4;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_MUL = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;
endpackage

// File: rtl/stage_execute_if.sv
// EX-side inputs, hazard controls and EX->MEM outputs of the execute stage.
interface stage_execute_if #(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int LANES = core_pkg::LANES
);
  localparam int DW = XLEN * LANES;

  logic          mem_clear;
  logic          mem_stall;
  logic [31:0]   ex_instr;
  logic          ex_reg_write;
  logic [1:0]    ex_result_src;
  logic          ex_vector_op;
  logic [3:0]    ex_alu_control;
  logic [DW-1:0] ex_src_a;
  logic [DW-1:0] ex_src_b;
  logic [DW-1:0] ex_write_data;
  logic [31:0]   ex_pc_plus_4;
  logic [DW-1:0] ex_imm_ext;
  logic [4:0]    ex_rd;
  logic          ex_stall;
  logic [31:0]   mem_instr;
  logic          mem_reg_write;
  logic [1:0]    mem_result_src;
  logic          mem_vector_op;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] mem_write_data;
  logic [31:0]   mem_pc_plus_4;
  logic [DW-1:0] mem_imm_ext;
  logic [4:0]    mem_rd;

  modport master (
    output mem_clear, mem_stall, ex_instr, ex_reg_write, ex_result_src, ex_vector_op,
           ex_alu_control, ex_src_a, ex_src_b, ex_write_data, ex_pc_plus_4, ex_imm_ext, ex_rd,
    input  ex_stall, mem_instr, mem_reg_write, mem_result_src, mem_vector_op, mem_alu_result,
           mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd
  );

  modport slave (
    input  mem_clear, mem_stall, ex_instr, ex_reg_write, ex_result_src, ex_vector_op,
           ex_alu_control, ex_src_a, ex_src_b, ex_write_data, ex_pc_plus_4, ex_imm_ext, ex_rd,
    output ex_stall, mem_instr, mem_reg_write, mem_result_src, mem_vector_op, mem_alu_result,
           mem_write_data, mem_pc_plus_4, mem_imm_ext, mem_rd
  );
endinterface

// File: rtl/lane_mul_seq.sv
// Lane-serial multiply sequencer: one lane product per BUSY cycle, result held in DONE.
module lane_mul_seq
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int LANES = core_pkg::LANES
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mul_op,
  input  logic                       vector_op,
  input  logic                       mem_stall,
  input  logic [LANES-1:0][XLEN-1:0] src_a,
  input  logic [LANES-1:0][XLEN-1:0] src_b,
  output logic                       ex_stall,
  output logic                       mul_done,
  output logic [LANES-1:0][XLEN-1:0] product
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  mul_state_t                 state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LANES-1:0][XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]              last_lane;

  assign last_lane = vector_op ? CW'(LANES - 1) : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      MUL_IDLE: if (mul_op) begin
        state_d = MUL_BUSY;
        cnt_d   = '0;
        prod_d  = '0;
      end
      MUL_BUSY: begin
        prod_d[cnt_q] = src_a[cnt_q] * src_b[cnt_q];
        if (cnt_q == last_lane) state_d = MUL_DONE;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      MUL_DONE: if (!mem_stall) state_d = MUL_IDLE;
      default:  state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign ex_stall = mul_op && (state_q != MUL_DONE);
  assign mul_done = (state_q == MUL_DONE);
  assign product  = prod_q;
endmodule

// File: rtl/stage_execute.sv
// Execute stage: scalar/vector lane ALU feeding the EX->MEM register.
// Multiply sequencer is built only when STAGE_EX_MUL_EN is defined.
module stage_execute
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int LANES = core_pkg::LANES
) (
  input  logic            clk,
  input  logic            reset,
  stage_execute_if.slave  bus
);
  localparam int DW  = XLEN * LANES;
  localparam int SHW = $clog2(XLEN);

  typedef struct packed {
    logic [31:0]   instr;
    logic          reg_write;
    logic [1:0]    result_src;
    logic          vector_op;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] write_data;
    logic [31:0]   pc_plus_4;
    logic [DW-1:0] imm_ext;
    logic [4:0]    rd;
  } ex_mem_t;

  logic [LANES-1:0][XLEN-1:0] a_l, b_l, alu_l;
  logic [DW-1:0]              result;
  logic                       ex_stall;
  ex_mem_t                    stage_q, stage_d;

  assign a_l = bus.ex_src_a;
  assign b_l = bus.ex_src_b;

  // Scalar mode computes lane 0 only; the upper lanes stay zero.
  always_comb begin
    alu_l = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.ex_vector_op || i == 0) begin
        case (bus.ex_alu_control)
          ALU_ADD: alu_l[i] = a_l[i] + b_l[i];
          ALU_SUB: alu_l[i] = a_l[i] - b_l[i];
          ALU_AND: alu_l[i] = a_l[i] & b_l[i];
          ALU_OR:  alu_l[i] = a_l[i] | b_l[i];
          ALU_XOR: alu_l[i] = a_l[i] ^ b_l[i];
          ALU_SLT: alu_l[i] = {{(XLEN-1){1'b0}}, ($signed(a_l[i]) < $signed(b_l[i]))};
          ALU_SLL: alu_l[i] = a_l[i] << b_l[i][SHW-1:0];
          ALU_SRL: alu_l[i] = a_l[i] >> b_l[i][SHW-1:0];
          default: alu_l[i] = '0;
        endcase
      end
    end
  end

`ifdef STAGE_EX_MUL_EN
  logic                       mul_done;
  logic [LANES-1:0][XLEN-1:0] prod_l;

  lane_mul_seq #(.XLEN(XLEN), .LANES(LANES)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .mul_op    (bus.ex_alu_control == ALU_MUL),
    .vector_op (bus.ex_vector_op),
    .mem_stall (bus.mem_stall),
    .src_a     (a_l),
    .src_b     (b_l),
    .ex_stall  (ex_stall),
    .mul_done  (mul_done),
    .product   (prod_l)
  );

  assign result = mul_done ? prod_l : alu_l;
`else
  assign ex_stall = 1'b0;
  assign result   = alu_l;
`endif

  assign bus.ex_stall = ex_stall;

  // Clear beats stall; a stalled multiply pushes bubbles into MEM.
  always_comb begin
    stage_d = stage_q;
    if (bus.mem_clear)      stage_d = '0;
    else if (bus.mem_stall) stage_d = stage_q;
    else if (ex_stall)      stage_d = '0;
    else begin
      stage_d.instr      = bus.ex_instr;
      stage_d.reg_write  = bus.ex_reg_write;
      stage_d.result_src = bus.ex_result_src;
      stage_d.vector_op  = bus.ex_vector_op;
      stage_d.alu_result = result;
      stage_d.write_data = bus.ex_write_data;
      stage_d.pc_plus_4  = bus.ex_pc_plus_4;
      stage_d.imm_ext    = bus.ex_imm_ext;
      stage_d.rd         = bus.ex_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign bus.mem_instr      = stage_q.instr;
  assign bus.mem_reg_write  = stage_q.reg_write;
  assign bus.mem_result_src = stage_q.result_src;
  assign bus.mem_vector_op  = stage_q.vector_op;
  assign bus.mem_alu_result = stage_q.alu_result;
  assign bus.mem_write_data = stage_q.write_data;
  assign bus.mem_pc_plus_4  = stage_q.pc_plus_4;
  assign bus.mem_imm_ext    = stage_q.imm_ext;
  assign bus.mem_rd         = stage_q.rd;
endmodule

// File: tb/tb_stage_execute.sv
// Directed bench for stage_execute: ALU vector table plus hazard/multiply sequences.
module tb_stage_execute;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stage_execute_if #(.XLEN(32), .LANES(4)) bus ();

  stage_execute dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    logic [3:0]   op;
    logic         vec;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] all_mem();
    return 512'({bus.mem_instr, bus.mem_reg_write, bus.mem_result_src, bus.mem_vector_op,
                 bus.mem_alu_result, bus.mem_write_data, bus.mem_pc_plus_4, bus.mem_imm_ext,
                 bus.mem_rd});
  endfunction

  function automatic logic [511:0] fwd_of(input int i);
    logic [31:0] w;
    logic [31:0] m;
    w = 32'hA5A5_0000 + 32'(i);
    m = 32'h5A5A_0000 + 32'(i);
    return 512'({32'hC0DE_0000 + 32'(i), i[0], i[1:0], {4{w}}, 32'h1000 + 32'(4*i),
                 {4{m}}, 5'(i + 1)});
  endfunction

  task automatic drive(input logic [3:0] op, input logic vec, input logic [127:0] a,
                       input logic [127:0] b, input int i);
    bus.ex_alu_control = op;
    bus.ex_vector_op   = vec;
    bus.ex_src_a       = a;
    bus.ex_src_b       = b;
    bus.ex_instr       = 32'hC0DE_0000 + 32'(i);
    bus.ex_reg_write   = i[0];
    bus.ex_result_src  = i[1:0];
    bus.ex_write_data  = {4{32'hA5A5_0000 + 32'(i)}};
    bus.ex_pc_plus_4   = 32'h1000 + 32'(4*i);
    bus.ex_imm_ext     = {4{32'h5A5A_0000 + 32'(i)}};
    bus.ex_rd          = 5'(i + 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef STAGE_EX_MUL_EN
  // Counts stall cycles (bounded), checking that MEM receives bubbles meanwhile.
  task automatic count_stalls(input string name, output int stalls);
    stalls = 0;
    while (bus.ex_stall && stalls < 20) begin
      stalls++;
      tick();
      chk({name, "_bubble"}, all_mem(), '0);
    end
  endtask
`endif

  initial begin
    logic [127:0] held;
    int           stalls;

    tbl[0]  = '{"add_scalar_wrap", 4'd0, 1'b0, {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hFFFF_FFFF},
                {32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h0000_0001}, 128'h0};
    tbl[1]  = '{"sub_vec", 4'd1, 1'b1, {32'd7, 32'd10, 32'd0, 32'd5}, {32'd8, 32'd10, 32'd1, 32'd3},
                {32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd2}};
    tbl[2]  = '{"and_vec", 4'd2, 1'b1, {32'hF0F0_F0F0, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0},
                {32'h0FF0_0FF0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFF},
                {32'h00F0_00F0, 32'h1234_0000, 32'h0000_FFFF, 32'h0}};
    tbl[3]  = '{"or_vec", 4'd3, 1'b1, {32'hA000_0000, 32'd1, 32'd0, 32'h0F},
                {32'h0500_0000, 32'd2, 32'd0, 32'hF0}, {32'hA500_0000, 32'd3, 32'd0, 32'hFF}};
    tbl[4]  = '{"xor_vec", 4'd4, 1'b1, {32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h1234_5678, 32'd0},
                {32'hFFFF_FFFF, 32'h5555_5555, 32'h1234_5678, 32'd1},
                {32'h0, 32'hFFFF_FFFF, 32'h0, 32'd1}};
    tbl[5]  = '{"slt_vec", 4'd5, 1'b1, {32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd7},
                {32'd0, 32'd5, 32'h7FFF_FFFF, 32'd3}, {32'd1, 32'd0, 32'd1, 32'd0}};
    tbl[6]  = '{"sll_vec", 4'd6, 1'b1, {32'd1, 32'd1, 32'h8000_0001, 32'h0F},
                {32'd31, 32'd0, 32'd1, 32'h24}, {32'h8000_0000, 32'd1, 32'd2, 32'hF0}};
    tbl[7]  = '{"srl_vec", 4'd7, 1'b1, {32'h8000_0000, 32'hFFFF_FFFF, 32'h10, 32'hF0},
                {32'd31, 32'h20, 32'd4, 32'd4}, {32'd1, 32'hFFFF_FFFF, 32'd1, 32'h0F}};
    tbl[8]  = '{"add_vec_nocarry", 4'd0, 1'b1, {32'hFFFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd10},
                {32'd1, 32'd2, 32'd1, 32'd20}, {32'd0, 32'd3, 32'h8000_0000, 32'd30}};
    tbl[9]  = '{"sub_scalar", 4'd1, 1'b0, {32'd9, 32'd9, 32'd9, 32'd0},
                {32'd1, 32'd1, 32'd1, 32'd1}, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}};
    tbl[10] = '{"reserved_op12", 4'd12, 1'b1, {4{32'h1234_5678}}, {4{32'h1}}, 128'h0};
    tbl[11] = '{"slt_scalar", 4'd5, 1'b0, {32'd1, 32'd1, 32'd1, 32'h8000_0000},
                {32'd2, 32'd2, 32'd2, 32'd0}, {32'd0, 32'd0, 32'd0, 32'd1}};

    // Reset with busy-looking inputs: outputs must still be zero.
    reset = 1'b1;
    bus.mem_clear = 1'b0;
    bus.mem_stall = 1'b0;
    drive(4'd0, 1'b1, {4{32'h1}}, {4{32'h2}}, 7);
    tick();
    tick();
    chk("reset_mem_zero", all_mem(), '0);
    chk("reset_ex_stall", 512'(bus.ex_stall), 512'(0));
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].op, tbl[i].vec, tbl[i].a, tbl[i].b, i);
      tick();
      chk({tbl[i].name, "_result"}, 512'(bus.mem_alu_result), 512'(tbl[i].exp));
      chk({tbl[i].name, "_fwd"},
          512'({bus.mem_instr, bus.mem_reg_write, bus.mem_result_src, bus.mem_write_data,
                bus.mem_pc_plus_4, bus.mem_imm_ext, bus.mem_rd}), fwd_of(i));
      chk({tbl[i].name, "_vec"}, 512'(bus.mem_vector_op), 512'(tbl[i].vec));
    end

    // mem_stall alone holds the previous capture.
    bus.mem_stall = 1'b1;
    drive(4'd0, 1'b1, {4{32'd100}}, {4{32'd1}}, 20);
    tick();
    chk("stall_hold", 512'(bus.mem_alu_result), 512'(tbl[11].exp));
    // Clear and stall together: clear wins.
    bus.mem_clear = 1'b1;
    tick();
    chk("clear_over_stall", all_mem(), '0);
    bus.mem_clear = 1'b0;
    bus.mem_stall = 1'b0;

`ifdef STAGE_EX_MUL_EN
    // Vector multiply: 5 stall cycles with bubbles, then all lanes.
    drive(4'd8, 1'b1, {32'd5, 32'd4, 32'd3, 32'd2}, {32'h8000_0000, 32'd8, 32'd7, 32'd6}, 21);
    chk("vmul_stall_idle", 512'(bus.ex_stall), 512'(1));
    count_stalls("vmul", stalls);
    chk("vmul_stall_cycles", 512'(stalls), 512'(5));
    tick();
    held = {32'h8000_0000, 32'd32, 32'd21, 32'd12};
    chk("vmul_result", 512'(bus.mem_alu_result), 512'(held));
    chk("vmul_fwd_rd", 512'(bus.mem_rd), 512'(22));

    // Scalar multiply under a 4-cycle mem_stall: waits in DONE, captures once released.
    drive(4'd8, 1'b0, {32'd9, 32'd9, 32'd9, 32'd7}, {32'd9, 32'd9, 32'd9, 32'd6}, 22);
    bus.mem_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("smul_stall_hold", 512'(bus.mem_alu_result), 512'(held));
    end
    chk("smul_done_no_stall", 512'(bus.ex_stall), 512'(0));
    bus.mem_stall = 1'b0;
    tick();
    chk("smul_result", 512'(bus.mem_alu_result), 512'(128'd42));

    // Reset while BUSY at cnt=2, then a reissued vector multiply runs in full.
    drive(4'd8, 1'b1, {32'd5, 32'd4, 32'd3, 32'd2}, {32'd1, 32'd1, 32'd1, 32'd1}, 23);
    tick();
    tick();
    tick();
    chk("rst_busy_stall", 512'(bus.ex_stall), 512'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy_mem_zero", all_mem(), '0);
    chk("rst_busy_idle_stall", 512'(bus.ex_stall), 512'(1));
    drive(4'd8, 1'b1, {32'd5, 32'd4, 32'd3, 32'd2}, {32'd10, 32'd10, 32'd10, 32'd10}, 24);
    count_stalls("remul", stalls);
    chk("remul_stall_cycles", 512'(stalls), 512'(5));
    tick();
    chk("remul_result", 512'(bus.mem_alu_result), 512'({32'd50, 32'd40, 32'd30, 32'd20}));
    drive(4'd0, 1'b0, '0, '0, 25);
`else
    // Without the sequencer opcode 8 is a reserved code: zero result, no stall.
    drive(4'd8, 1'b1, {4{32'd3}}, {4{32'd5}}, 21);
    chk("mul_off_no_stall", 512'(bus.ex_stall), 512'(0));
    tick();
    chk("mul_off_result", 512'(bus.mem_alu_result), 512'(0));
    chk("mul_off_rd", 512'(bus.mem_rd), 512'(22));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
